keypad_scanner: RTL and testbench

- Reads a 4x4 matrix keypad and delivers debounced key codes for operand entry into the signed 8-bit adder.
- It is the input counterpart of the 7-segment digit scanner. It drives one active-low row at a time, using the same one-hot-low pattern as the digit enables, and samples the active-low columns.
- It emits one single-cycle key_valid pulse and a 4-bit code per debounced press.

---
 rtl/keypad_scanner.sv | 171 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks one active-low row per scan tick, debounces
// presses and releases, and emits a one-clk key_valid pulse with {row,col} code.
module keypad_scanner #(
    parameter int CLK_DIV      = 50000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int             PW        = $clog2(CLK_DIV);
    localparam logic [PW-1:0]  PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [3:0]     DEB       = 4'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {
        S_SCAN     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_HELD     = 2'd2,
        S_RELEASE  = 2'd3
    } state_t;

    logic [3:0]    r_sync1;
    logic [3:0]    r_col_s;
    logic [PW-1:0] r_presc;
    state_t        r_state;
    logic [1:0]    r_row_idx;
    logic [3:0]    r_col_pat;
    logic [3:0]    r_cnt;
    logic [3:0]    r_key_code;
    logic          r_key_valid;

    logic          w_tick;
    logic          w_col_valid;
    logic [1:0]    w_col_idx;
    logic [3:0]    w_cnt_inc;
    state_t        w_state_nxt;
    logic [1:0]    w_row_idx_nxt;
    logic [3:0]    w_col_pat_nxt;
    logic [3:0]    w_cnt_nxt;
    logic          w_accept;

    assign w_tick    = (r_presc == PRESC_MAX);
    assign w_cnt_inc = r_cnt + 4'd1;

    // A single low column is a valid key; all-high is idle, multiple lows are ghosting.
    always_comb begin
        w_col_valid = 1'b1;
        w_col_idx   = 2'd0;
        case (r_col_s)
            4'b1110: w_col_idx = 2'd0;
            4'b1101: w_col_idx = 2'd1;
            4'b1011: w_col_idx = 2'd2;
            4'b0111: w_col_idx = 2'd3;
            default: w_col_valid = 1'b0;
        endcase
    end

    // Synchronizer and prescaler
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 4'b1111;
            r_col_s <= 4'b1111;
            r_presc <= '0;
        end else begin
            r_sync1 <= col_in;
            r_col_s <= r_sync1;
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
        end
    end

    // FSM state register (with the datapath registers it steers)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_SCAN;
            r_row_idx   <= 2'd0;
            r_col_pat   <= 4'b1111;
            r_cnt       <= 4'd0;
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_row_idx   <= w_row_idx_nxt;
            r_col_pat   <= w_col_pat_nxt;
            r_cnt       <= w_cnt_nxt;
            r_key_valid <= w_accept;
            if (w_accept)
                r_key_code <= {r_row_idx, w_col_idx};
        end
    end

    // FSM next-state logic; everything moves only on a scan tick.
    always_comb begin
        w_state_nxt   = r_state;
        w_row_idx_nxt = r_row_idx;
        w_col_pat_nxt = r_col_pat;
        w_cnt_nxt     = r_cnt;
        w_accept      = 1'b0;
        if (w_tick) begin
            case (r_state)
                S_SCAN: begin
                    if (w_col_valid) begin
                        w_col_pat_nxt = r_col_s;
                        w_cnt_nxt     = 4'd1;
                        if (DEB == 4'd1) begin
                            w_accept    = 1'b1;
                            w_state_nxt = S_HELD;
                        end else begin
                            w_state_nxt = S_DEBOUNCE;
                        end
                    end else begin
                        w_row_idx_nxt = r_row_idx + 2'd1;
                    end
                end
                S_DEBOUNCE: begin
                    if (r_col_s == r_col_pat) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc >= DEB) begin
                            w_accept    = 1'b1;
                            w_state_nxt = S_HELD;
                        end
                    end else begin
                        // Same row is resampled on the next tick.
                        w_cnt_nxt   = 4'd0;
                        w_state_nxt = S_SCAN;
                    end
                end
                S_HELD: begin
                    if (r_col_s == 4'b1111) begin
                        if (DEB == 4'd1) begin
                            w_cnt_nxt     = 4'd0;
                            w_row_idx_nxt = r_row_idx + 2'd1;
                            w_state_nxt   = S_SCAN;
                        end else begin
                            w_cnt_nxt   = 4'd1;
                            w_state_nxt = S_RELEASE;
                        end
                    end
                end
                S_RELEASE: begin
                    if (r_col_s == 4'b1111) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc >= DEB) begin
                            w_cnt_nxt     = 4'd0;
                            w_row_idx_nxt = r_row_idx + 2'd1;
                            w_state_nxt   = S_SCAN;
                        end
                    end else begin
                        w_cnt_nxt   = 4'd0;
                        w_state_nxt = S_HELD;
                    end
                end
                default: w_state_nxt = S_SCAN;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        row_out  = ~(4'b0001 << r_row_idx);
        key_held = (r_state == S_HELD) || (r_state == S_RELEASE);
    end

    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (CLK_DIV=4, DEBOUNCE_CNT=3) with a keypad
// model driving col_in from row_out and a scoreboard of expected key codes.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [3:0] kp_pat [4];
    logic [3:0] rows   [4];
    logic [3:0] sb_q [$];
    logic       prev_valid = 1'b0;
    int         n_test = 0;
    int         n_fail = 0;

    keypad_scanner #(.CLK_DIV(4), .DEBOUNCE_CNT(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .col_in    (col_in),
        .row_out   (row_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Keypad: the driven row's pressed pattern appears on the columns.
    always_comb begin
        col_in = 4'b1111;
        for (int r = 0; r < 4; r++)
            if (row_out[r] == 1'b0) col_in = kp_pat[r];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_test++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every pulse must match the oldest expected code.
    always @(negedge clk) begin
        check("row_onehot", 32'($countones(~row_out)), 32'd1);
        if (key_valid) begin
            check("no_back_to_back", {31'd0, prev_valid}, 32'd0);
            check("pulse_expected", {31'd0, sb_q.size() > 0}, 32'd1);
            if (sb_q.size() > 0) check("sb_code", {28'd0, key_code}, {28'd0, sb_q.pop_front()});
        end
        prev_valid <= key_valid;
    end

    task automatic wait_row(input string tag, input logic [3:0] exp);
        int k = 0;
        do begin @(negedge clk); k++; end while (row_out !== exp && k < 100);
        check(tag, {28'd0, row_out}, {28'd0, exp});
    endtask

    task automatic wait_pulse(input string tag);
        int k = 0;
        do begin @(negedge clk); k++; end while (key_valid !== 1'b1 && k < 200);
        check(tag, {31'd0, key_valid}, 32'd1);
    endtask

    task automatic wait_release(input string tag);
        int k = 0;
        do begin @(negedge clk); k++; end while (key_held !== 1'b0 && k < 200);
        check(tag, {31'd0, key_held}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rows[0] = 4'b1110; rows[1] = 4'b1101; rows[2] = 4'b1011; rows[3] = 4'b0111;
        for (int r = 0; r < 4; r++) kp_pat[r] = 4'b1111;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_row", {28'd0, row_out}, 32'h0000_000e);
        check("rst_code", {28'd0, key_code}, 32'd0);
        check("rst_valid", {31'd0, key_valid}, 32'd0);
        check("rst_held", {31'd0, key_held}, 32'd0);
        rst = 1'b0;

        // Idle scan: row advances every 4 clks, first change on the 4th edge.
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            check("idle_row", {28'd0, row_out}, {28'd0, rows[(n / 4) % 4]});
            check("idle_valid", {31'd0, key_valid}, 32'd0);
            check("idle_held", {31'd0, key_held}, 32'd0);
        end

        // Row 2 col 1: pulse exactly 12 clks after row 2 is driven.
        kp_pat[2] = 4'b1101;
        sb_q.push_back(4'b1001);
        wait_row("reach_row2", 4'b1011);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            check("press_valid", {31'd0, key_valid}, {31'd0, k == 12});
            check("press_row_frozen", {28'd0, row_out}, 32'h0000_000b);
        end
        check("press_code", {28'd0, key_code}, 32'h0000_0009);
        check("press_held", {31'd0, key_held}, 32'd1);

        // Release then re-press the same key.
        kp_pat[2] = 4'b1111;
        wait_release("release1");
        check("release1_row", {28'd0, row_out}, 32'h0000_0007);
        sb_q.push_back(4'b1001);
        kp_pat[2] = 4'b1101;
        wait_pulse("repress_pulse");
        check("repress_code", {28'd0, key_code}, 32'h0000_0009);
        kp_pat[2] = 4'b1111;
        wait_release("release2");

        // Bounce on row 0 col 3: detect at tick 1, open on tick 2, accept 20 clks in.
        kp_pat[0] = 4'b0111;
        sb_q.push_back(4'b0011);
        wait_row("reach_row0", 4'b1110);
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            if (k == 5) kp_pat[0] = 4'b1111;
            if (k == 8) kp_pat[0] = 4'b0111;
            check("bounce_valid", {31'd0, key_valid}, {31'd0, k == 20});
            check("bounce_row", {28'd0, row_out}, 32'h0000_000e);
        end
        check("bounce_code", {28'd0, key_code}, 32'h0000_0003);
        kp_pat[0] = 4'b1111;
        wait_release("release3");

        // Two low columns on row 1: ignored, scanning continues.
        kp_pat[1] = 4'b1100;
        begin
            logic seen3 = 1'b0;
            for (int k = 1; k <= 16; k++) begin
                @(negedge clk);
                if (row_out == 4'b0111) seen3 = 1'b1;
                check("invalid_held", {31'd0, key_held}, 32'd0);
                check("invalid_valid", {31'd0, key_valid}, 32'd0);
            end
            check("invalid_scan_on", {31'd0, seen3}, 32'd1);
        end
        kp_pat[1] = 4'b1111;

        // Row 2 col 0, then a release that bounces back low on the 2nd tick.
        kp_pat[2] = 4'b1110;
        sb_q.push_back(4'b1000);
        wait_pulse("rb_pulse");
        kp_pat[2] = 4'b1111;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (k == 5) kp_pat[2] = 4'b1110;
            check("rb_held", {31'd0, key_held}, 32'd1);
            check("rb_valid", {31'd0, key_valid}, 32'd0);
            check("rb_row", {28'd0, row_out}, 32'h0000_000b);
        end
        check("rb_code", {28'd0, key_code}, 32'h0000_0008);

        // Reset while HELD; the held key needs a full new debounce.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_row", {28'd0, row_out}, 32'h0000_000e);
        check("mid_rst_held", {31'd0, key_held}, 32'd0);
        check("mid_rst_code", {28'd0, key_code}, 32'd0);
        check("mid_rst_valid", {31'd0, key_valid}, 32'd0);
        sb_q.push_back(4'b1000);
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            check("post_rst_valid", {31'd0, key_valid}, {31'd0, k == 20});
        end
        check("post_rst_code", {28'd0, key_code}, 32'h0000_0008);
        kp_pat[2] = 4'b1111;
        wait_release("release_final");

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
        $finish;
    end

endmodule
